// File: rtl/code_rom_loader_pkg.sv
// Shared types and default sizing for the code ROM loader.
package code_rom_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CSUM = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    localparam int unsigned DEF_ROM_BYTES = 32;
    localparam int unsigned DEF_ADDR_W    = 12;

endpackage

// File: rtl/code_rom_loader_if.sv
// Host byte stream and ROM write port of the code ROM loader.
interface code_rom_loader_if #(
    parameter int unsigned ADDR_W = code_rom_loader_pkg::DEF_ADDR_W
);
    logic              host_valid;
    logic [7:0]        host_data;
    logic              host_ready;
    logic              rom_wr_en;
    logic [ADDR_W-1:0] rom_wr_addr;
    logic [7:0]        rom_wr_data;

    // master: the loader (accepts host bytes, drives ROM writes)
    modport master (
        input  host_valid, host_data,
        output host_ready, rom_wr_en, rom_wr_addr, rom_wr_data
    );

    // slave: host and ROM side
    modport slave (
        output host_valid, host_data,
        input  host_ready, rom_wr_en, rom_wr_addr, rom_wr_data
    );
endinterface

// File: rtl/code_rom_loader.sv
// Loads a checksummed byte image from a host stream into the code ROM,
// holding the CPU off the ROM read path while the load is in progress.
module code_rom_loader
    import code_rom_loader_pkg::*;
#(
    parameter int unsigned ROM_BYTES = DEF_ROM_BYTES,
    parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_code_rom_n,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              load_abort,
    code_rom_loader_if.master bus,
    output logic              cpu_grant,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic [7:0]        checksum
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [7:0]        csum_q, csum_d;
    logic              err_q, err_d;

    logic              host_ready;
    logic              wr_en;
    logic [ADDR_W:0]   end_addr;
    logic              range_bad;

    // One extra bit so base+len cannot wrap past the ROM size check
    assign end_addr  = {1'b0, load_base} + {1'b0, load_len};
    assign range_bad = (load_len == '0) || (end_addr > (ADDR_W+1)'(ROM_BYTES));

    always_ff @(posedge clk or negedge reset_code_rom_n) begin
        if (!reset_code_rom_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            csum_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            count_q <= count_d;
            csum_q  <= csum_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        count_d    = count_q;
        csum_d     = csum_q;
        err_d      = err_q;
        cpu_grant  = 1'b0;
        load_busy  = 1'b1;
        host_ready = 1'b0;
        wr_en      = 1'b0;
        load_done  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cpu_grant = 1'b1;
                load_busy = 1'b0;
                if (load_start) begin
                    base_d  = load_base;
                    len_d   = load_len;
                    count_d = '0;
                    csum_d  = '0;
                    err_d   = range_bad;
                    state_d = range_bad ? ST_ERR : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_abort) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else begin
                    host_ready = 1'b1;
                    if (bus.host_valid) begin
                        wr_en   = 1'b1;
                        count_d = count_q + ADDR_W'(1);
                        csum_d  = csum_q + bus.host_data;
                        if (count_q == len_q - ADDR_W'(1)) state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (load_abort) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else begin
                    host_ready = 1'b1;
                    if (bus.host_valid) begin
                        if (bus.host_data == csum_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                load_done = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_ERR: begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.host_ready  = host_ready;
    assign bus.rom_wr_en   = wr_en;
    assign bus.rom_wr_addr = base_q + count_q;
    assign bus.rom_wr_data = bus.host_data;
    assign load_err        = err_q;
    assign checksum        = csum_q;

endmodule

// File: doc/code_rom_loader.md
CODE_ROM_LOADER -- requirements
Module: code_rom_loader

Interface
REQ-001 The block SHALL have parameter ROM_BYTES, default 32, meaning the code ROM size in bytes.
REQ-002 The block SHALL have parameter ADDR_W, default 12, meaning the ROM address width.
REQ-003 The block SHALL have port clk, input, 1, the rising-edge clock.
REQ-004 The block SHALL have port reset_code_rom_n, input, 1, the reset (asynchronous, active-low); the clock is clk.
REQ-005 The block SHALL have port load_start, input, 1, a single-cycle request to begin a load.
REQ-006 The block SHALL have port load_base, input, ADDR_W, the first byte address, sampled on an accepted load_start.
REQ-007 The block SHALL have port load_len, input, ADDR_W, the byte count, sampled on an accepted load_start.
REQ-008 The block SHALL have port load_abort, input, 1, which cancels an active load.
REQ-009 The block SHALL have port host_valid, input, 1, meaning the host byte is valid.
REQ-010 The block SHALL have port host_data, input, 8, the host byte (a payload byte, then a trailing checksum byte).
REQ-011 The block SHALL have port host_ready, output, 1, meaning the block accepts a byte this cycle.
REQ-012 The block SHALL have port rom_wr_en, output, 1, the ROM byte write strobe.
REQ-013 The block SHALL have port rom_wr_addr, output, ADDR_W, the ROM write address.
REQ-014 The block SHALL have port rom_wr_data, output, 8, the ROM write byte.
REQ-015 The block SHALL have port cpu_grant, output, 1, meaning the CPU owns the ROM read path (fetch mux select).
REQ-016 The block SHALL have port load_busy, output, 1, meaning a load is in progress.
REQ-017 The block SHALL have port load_done, output, 1, a single-cycle completion pulse.
REQ-018 The block SHALL have port load_err, output, 1, a sticky error flag, cleared by the next accepted load_start.
REQ-019 The block SHALL have port checksum, output, 8, the running mod-256 sum of the payload bytes.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, CSUM, DONE and ERR.
REQ-021 In IDLE, cpu_grant SHALL be 1, host_ready SHALL be 0, and rom_wr_en SHALL be 0.
REQ-022 In IDLE, on load_start=1 the block SHALL latch load_base and load_len, clear count, clear checksum and clear load_err.
REQ-023 After latching, if load_len==0 or load_base+load_len>ROM_BYTES (compared at ADDR_W+1 bits, so there is no wrap), the next state SHALL be ERR; otherwise it SHALL be LOAD.
REQ-024 In any state other than IDLE, load_start SHALL be ignored.
REQ-025 In LOAD, CSUM, DONE and ERR, cpu_grant SHALL be 0 and load_busy SHALL be 1.
REQ-026 In LOAD, host_ready SHALL be 1.
REQ-027 A LOAD handshake SHALL be the same-cycle combination host_valid and host_ready, which drives rom_wr_en=1, rom_wr_addr=base+count and rom_wr_data=host_data combinationally.
REQ-028 On each LOAD handshake, count SHALL increment and checksum SHALL update to checksum+host_data mod 256.
REQ-029 When the handshake with count==len-1 completes, the next state SHALL be CSUM.
REQ-030 A cycle with host_valid=0 SHALL cause no write and no state change (zero-throughput stalls are allowed).
REQ-031 In CSUM, host_ready SHALL be 1 and rom_wr_en SHALL be 0.
REQ-032 On a CSUM handshake, if host_data equals checksum the next state SHALL be DONE; otherwise it SHALL be ERR.
REQ-033 DONE SHALL last one cycle with load_done=1, then the next state SHALL be IDLE.
REQ-034 ERR SHALL last one cycle, set load_err to 1, and then the next state SHALL be IDLE.
REQ-035 In ERR, load_done SHALL be 0.
REQ-036 If load_abort=1 in LOAD or CSUM, the next state SHALL be ERR.
REQ-037 In that abort cycle, a handshake SHALL NOT occur: host_ready is forced to 0 and rom_wr_en is forced to 0.
REQ-038 Bytes already written before an abort SHALL remain in the ROM.
REQ-039 Within a single load, the write latency SHALL be 0 cycles from handshake to rom_wr_en.
REQ-040 The latency from the final CSUM handshake to load_done SHALL be 1 cycle.
REQ-041 cpu_grant SHALL return to 1 in the cycle after DONE or ERR.

Reset
REQ-042 Asserting reset_code_rom_n low SHALL asynchronously force the state to IDLE, count to 0, checksum to 0 and load_err to 0.
REQ-043 During and after reset, the outputs SHALL be: cpu_grant=1, host_ready=0, rom_wr_en=0, load_busy=0, load_done=0.
REQ-044 A reset asserted mid-load SHALL abandon the load without raising load_err.
REQ-045 Deassertion of reset_code_rom_n SHALL be synchronised externally.

Structure
REQ-046 A shared package SHALL hold the FSM state enum (3-bit) and the default constants for ROM_BYTES and ADDR_W.
REQ-047 The block SHALL be implemented as a single module with no sub-modules.

Verification
REQ-048 Bench scenario, normal load: base=0, len=4, bytes 13,00,00,93, checksum A6 -> 4 writes at addr 0..3, load_done pulse, load_err=0, checksum=A6.
REQ-049 Bench scenario, host stalls: base=8, len=2, host_valid toggled 1,0,0,1 -> exactly 2 writes at addr 8 and 9, none in the stall cycles.
REQ-050 Bench scenario, bad checksum: len=1, byte 05, checksum 06 -> write at addr base, load_err=1, no load_done, cpu_grant=1 afterwards.
REQ-051 Bench scenario, range error: base=30, len=4 (ROM_BYTES=32) -> ERR next cycle, zero writes, load_err=1; also len=0 -> load_err=1.
REQ-052 Bench scenario, abort: abort after 2 of 4 bytes with host_valid=1 in that cycle -> no write in the abort cycle, load_err=1, then IDLE.
REQ-053 Bench scenario, reset mid-LOAD: assert reset during LOAD -> IDLE immediately, all outputs at reset values, load_err=0; a following load_start while busy is ignored.
